if_stage_req_fetch: RTL

//  Parametrised instruction-fetch stage for the req/addr_ok/data_ok SRAM-like bus.

---
 rtl/if_stage_req_fetch_if.sv | 22 ++
 rtl/if_stage_req_fetch.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/if_stage_req_fetch_if.sv
// Instruction-side SRAM-like bus: the fetch stage drives req/addr and the bridge answers
// with addr_ok (request accepted) and data_ok/rdata (oldest request returns).
interface if_stage_req_fetch_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/if_stage_req_fetch.sv
// Instruction-fetch stage for the req/addr_ok/data_ok bus: keeps up to MAX_OUTST fetches in
// flight, buffers returns in an IBUF_DEPTH FIFO toward ID and drops stale data after redirects.
module if_stage_req_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h1c000000,
  parameter int          IBUF_DEPTH = 4,
  parameter int          MAX_OUTST  = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  if_stage_req_fetch_if.master inst_sram,
  input  logic                 flush,
  input  logic [31:0]          flush_pc,
  input  logic                 br_taken,
  input  logic [31:0]          br_target,
  input  logic                 id_allowin,
  output logic                 if_to_id_valid,
  output logic [31:0]          if_inst,
  output logic [31:0]          if_pc,
  output logic                 if_excp_adef
);
  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = $clog2(IBUF_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int QW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic          active;
  logic [31:0]   fetch_pc;
  logic [31:0]   pend_addr;
  logic          pending;
  logic          pend_stale;
  logic          halted;
  logic [OW-1:0] outst;
  logic [OW-1:0] discard;
  logic [OW-1:0] outst_nx;

  logic [31:0]   ibuf_pc   [IBUF_DEPTH];
  logic [31:0]   ibuf_inst [IBUF_DEPTH];
  logic          ibuf_adef [IBUF_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;

  logic [31:0]   pcq [MAX_OUTST];
  logic [QW-1:0] pcq_wr;
  logic [QW-1:0] pcq_rd;

  logic          redirect;
  logic [31:0]   target;
  logic          misal;
  logic          fifo_empty;
  logic          fifo_full;
  logic          can_issue;
  logic          req;
  logic          acc;
  logic          dok;
  logic          drop;
  logic          push_data;
  logic          push_adef;
  logic          push;
  logic          pop;

  function automatic logic [QW-1:0] qinc(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUTST - 1)) ? '0 : p + QW'(1);
  endfunction

  always_comb begin
    redirect   = flush | br_taken;
    target     = flush ? flush_pc : br_target;
    misal      = fetch_pc[1:0] != 2'b00;
    fifo_empty = fifo_cnt == '0;
    fifo_full  = fifo_cnt == CW'(IBUF_DEPTH);
    // Outstanding requests reserve FIFO space so every return always has a slot.
    can_issue  = active & ~pending & ~halted & ~misal
               & ((32'(outst) + 32'(fifo_cnt)) < IBUF_DEPTH)
               & (32'(outst) < MAX_OUTST);
    req        = pending | can_issue;
    acc        = req & inst_sram.addr_ok;
    dok        = inst_sram.data_ok;
    drop       = dok & (redirect | (discard != '0));
    push_data  = dok & ~drop;
    push_adef  = active & misal & ~halted & ~pending & (outst == '0) & (discard == '0)
               & ~fifo_full & ~redirect;
    push       = push_data | push_adef;
    if_to_id_valid = ~fifo_empty & ~redirect;
    pop        = if_to_id_valid & id_allowin;
    outst_nx   = outst + OW'(acc) - OW'(dok);
  end

  assign inst_sram.req   = req;
  assign inst_sram.wr    = 1'b0;
  assign inst_sram.size  = 2'b10;
  assign inst_sram.addr  = pending ? pend_addr : fetch_pc;
  assign inst_sram.wdata = 32'h0;

  assign if_pc        = ibuf_pc[rd_ptr];
  assign if_inst      = ibuf_inst[rd_ptr];
  assign if_excp_adef = ibuf_adef[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      active     <= 1'b0;
      fetch_pc   <= RESET_PC;
      pending    <= 1'b0;
      pend_stale <= 1'b0;
      halted     <= 1'b0;
      outst      <= '0;
      discard    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      pcq_wr     <= '0;
      pcq_rd     <= '0;
    end else begin
      active     <= 1'b1;
      pending    <= req & ~inst_sram.addr_ok;
      // A request still waiting for addr_ok across a redirect must not advance fetch_pc.
      pend_stale <= req & ~inst_sram.addr_ok & (redirect | pend_stale);
      outst      <= outst_nx;
      if (acc) pcq_wr <= qinc(pcq_wr);
      if (dok) pcq_rd <= qinc(pcq_rd);
      if (redirect) begin
        fetch_pc <= target;
        halted   <= 1'b0;
        discard  <= outst_nx + OW'(req & ~inst_sram.addr_ok);
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (acc & ~(pending & pend_stale)) fetch_pc <= fetch_pc + 32'd4;
        if (drop) discard <= discard - OW'(1);
        if (push_adef) halted <= 1'b1;
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (can_issue) pend_addr <= fetch_pc;
    if (acc) pcq[pcq_wr] <= inst_sram.addr;
    if (push) begin
      ibuf_pc[wr_ptr]   <= push_adef ? fetch_pc : pcq[pcq_rd];
      ibuf_inst[wr_ptr] <= push_adef ? 32'h0 : inst_sram.rdata;
      ibuf_adef[wr_ptr] <= push_adef;
    end
  end

  // A return with nothing in flight means the bridge and this stage disagree.
  assert property (@(posedge clk) disable iff (!resetn) !(dok && (outst == '0)));

endmodule
